// File: rtl/cell_grid_if.sv
// Pixel-to-cell mapper bus: raw VGA counters and board in,
// registered cell/overlay information out to the colour stage.
interface cell_grid_if #(
  parameter int COLS = 16,
  parameter int ROWS = 16
);
  localparam int IDX_W = $clog2(COLS * ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  logic                   pixel_tick;
  logic [9:0]             hc;
  logic [9:0]             vc;
  logic [COLS*ROWS-1:0]   board;
  logic [CW-1:0]          cursor_col;
  logic [RW-1:0]          cursor_row;
  logic [1:0]             mode;

  logic                   out_valid;
  logic                   in_grid;
  logic [IDX_W-1:0]       cell_index;
  logic                   cell_state;
  logic                   grid_line;
  logic                   cursor_hit;
  logic                   pix_on;

  modport master (
    output pixel_tick, hc, vc, board,
    output cursor_col, cursor_row, mode,
    input  out_valid, in_grid, cell_index,
    input  cell_state, grid_line, cursor_hit, pix_on
  );

  modport slave (
    input  pixel_tick, hc, vc, board,
    input  cursor_col, cursor_row, mode,
    output out_valid, in_grid, cell_index,
    output cell_state, grid_line, cursor_hit, pix_on
  );
endinterface

// File: rtl/cell_grid_mapper.sv
// Two-stage pixel-to-cell mapper: incremental col/row trackers,
// then registered cell lookup and overlay flags.
module cell_grid_mapper #(
  parameter int COLS      = 16,
  parameter int ROWS      = 16,
  parameter int CELL_SIZE = 30,
  parameter int H_OFFSET  = 224,
  parameter int V_OFFSET  = 35,
  parameter int IDX_W     = $clog2(COLS * ROWS)
) (
  input  logic       clk,
  input  logic       rst,
  cell_grid_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(CELL_SIZE);

  localparam logic [9:0]    HOFF    = 10'(H_OFFSET);
  localparam logic [9:0]    VOFF    = 10'(V_OFFSET);
  localparam logic [SW-1:0] SUB_MAX = SW'(CELL_SIZE - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW:0]   COL_LIM = (CW + 1)'(COLS);
  localparam logic [RW:0]   ROW_LIM = (RW + 1)'(ROWS);

  typedef struct packed {
    logic          h_act;
    logic [CW-1:0] col;
    logic [SW-1:0] hsub;
    logic          v_act;
    logic [RW-1:0] row;
    logic [SW-1:0] vsub;
    logic          valid;
  } s1_t;

  s1_t s1_q;
  s1_t s1_d;

  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = bus.pixel_tick;
    if (bus.pixel_tick) begin
      if (bus.hc == HOFF) begin
        s1_d.h_act = 1'b1;
        s1_d.col   = '0;
        s1_d.hsub  = '0;
      end else if (s1_q.h_act) begin
        if (s1_q.hsub == SUB_MAX) begin
          s1_d.hsub = '0;
          if (s1_q.col == COL_MAX) s1_d.h_act = 1'b0;
          else s1_d.col = s1_q.col + 1'b1;
        end else begin
          s1_d.hsub = s1_q.hsub + 1'b1;
        end
      end
      // hc==0 never coincides with hc==H_OFFSET, so the trackers are disjoint
      if (bus.hc == '0) begin
        if (bus.vc == '0) begin
          s1_d.v_act = 1'b0;
        end else if (bus.vc == VOFF) begin
          s1_d.v_act = 1'b1;
          s1_d.row   = '0;
          s1_d.vsub  = '0;
        end else if (s1_q.v_act) begin
          if (s1_q.vsub == SUB_MAX) begin
            s1_d.vsub = '0;
            if (s1_q.row == ROW_MAX) s1_d.v_act = 1'b0;
            else s1_d.row = s1_q.row + 1'b1;
          end else begin
            s1_d.vsub = s1_q.vsub + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  logic             in_g;
  logic [IDX_W-1:0] idx;
  logic             cur_ok;
  logic             st;
  logic             gl;
  logic             hit;
  logic             pix;

  always_comb begin
    in_g   = s1_q.h_act & s1_q.v_act;
    idx    = in_g ? {s1_q.row, s1_q.col} : '0;
    cur_ok = ({1'b0, bus.cursor_col} < COL_LIM) &
             ({1'b0, bus.cursor_row} < ROW_LIM);
    st     = in_g & bus.board[idx];
    gl     = in_g & ((s1_q.hsub == '0) | (s1_q.vsub == '0));
    hit    = in_g & cur_ok &
             (s1_q.col == bus.cursor_col) &
             (s1_q.row == bus.cursor_row);
    pix    = in_g & ((bus.mode[0] & gl) |
                     (st ^ (bus.mode[1] & hit)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.in_grid    <= 1'b0;
      bus.cell_index <= '0;
      bus.cell_state <= 1'b0;
      bus.grid_line  <= 1'b0;
      bus.cursor_hit <= 1'b0;
      bus.pix_on     <= 1'b0;
    end else begin
      bus.out_valid  <= s1_q.valid;
      bus.in_grid    <= in_g;
      bus.cell_index <= idx;
      bus.cell_state <= st;
      bus.grid_line  <= gl;
      bus.cursor_hit <= hit;
      bus.pix_on     <= pix;
    end
  end
endmodule

// File: tb/tb_cell_grid_mapper.sv
// Bench for cell_grid_mapper: default and 32x8x8 variants driven
// with shared frame sweeps against an arithmetic reference model.
module tb_cell_grid_mapper;
  localparam int HO = 224;
  localparam int VO = 35;
  localparam int SWEEP_END = 705;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cell_grid_if #(.COLS(16), .ROWS(16)) b0 ();
  cell_grid_if #(.COLS(32), .ROWS(8))  b1 ();

  cell_grid_mapper #(
    .COLS(16), .ROWS(16), .CELL_SIZE(30),
    .H_OFFSET(HO), .V_OFFSET(VO)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  cell_grid_mapper #(
    .COLS(32), .ROWS(8), .CELL_SIZE(8),
    .H_OFFSET(HO), .V_OFFSET(VO)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    bit in_g;
    int idx;
    bit st;
    bit gl;
    bit hit;
    bit pix;
    bit vld;
  } out_t;

  typedef struct {
    int frm;
    int d;
    int hc;
    int vc;
    bit in_g;
    int idx;
    bit st;
    bit gl;
    bit hit;
    bit pix;
    int seen;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;
  int prints = 0;

  logic [255:0] board;
  logic [1:0]   mode;
  int cc0, cr0, cc1, cr1;

  bit frame_ok;
  bit last_ok;
  bit prev_tick;
  int last_hc, last_vc;
  int cur_hc, cur_vc;
  int cur_frame;
  int idle_pct;
  bit sweep[525];

  function automatic void add(int frm, int d, int hc, int vc,
                              bit in_g, int idx, bit st, bit gl,
                              bit hit, bit pix);
    vec_t v;
    v.frm = frm; v.d = d; v.hc = hc; v.vc = vc;
    v.in_g = in_g; v.idx = idx; v.st = st; v.gl = gl;
    v.hit = hit; v.pix = pix; v.seen = 0;
    tbl.push_back(v);
  endfunction

  function automatic out_t model(int d, int hc, int vc, bit ok, bit vld);
    out_t o;
    int c, r, s, cc, cr, col, row, hs, vs;
    c  = (d == 0) ? 16 : 32;
    r  = (d == 0) ? 16 : 8;
    s  = (d == 0) ? 30 : 8;
    cc = (d == 0) ? cc0 : cc1;
    cr = (d == 0) ? cr0 : cr1;
    o.in_g = 0; o.idx = 0; o.st = 0; o.gl = 0;
    o.hit = 0; o.pix = 0; o.vld = vld;
    if (ok && hc >= HO && hc < HO + c * s &&
        vc >= VO && vc < VO + r * s) begin
      col = (hc - HO) / s;
      hs  = (hc - HO) % s;
      row = (vc - VO) / s;
      vs  = (vc - VO) % s;
      o.in_g = 1;
      o.idx  = row * c + col;
      o.st   = board[o.idx];
      o.gl   = (hs == 0) || (vs == 0);
      o.hit  = (col == cc) && (row == cr);
      o.pix  = (mode[0] && o.gl) || (o.st ^ (mode[1] && o.hit));
    end
    return o;
  endfunction

  function automatic out_t act(int d);
    out_t o;
    if (d == 0) begin
      o.in_g = b0.in_grid;  o.idx = int'(b0.cell_index);
      o.st = b0.cell_state; o.gl = b0.grid_line;
      o.hit = b0.cursor_hit; o.pix = b0.pix_on; o.vld = b0.out_valid;
    end else begin
      o.in_g = b1.in_grid;  o.idx = int'(b1.cell_index);
      o.st = b1.cell_state; o.gl = b1.grid_line;
      o.hit = b1.cursor_hit; o.pix = b1.pix_on; o.vld = b1.out_valid;
    end
    return o;
  endfunction

  function automatic bit differs(out_t a, out_t e, bit with_vld);
    return a.in_g != e.in_g || a.idx != e.idx || a.st != e.st ||
           a.gl != e.gl || a.hit != e.hit || a.pix != e.pix ||
           (with_vld && a.vld != e.vld);
  endfunction

  task automatic compare(string name, int d, out_t a, out_t e, bit with_vld);
    checks++;
    if (differs(a, e, with_vld)) begin
      errors++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s d%0d px=(%0d,%0d) got in=%0b idx=%0d st=%0b gl=%0b hit=%0b pix=%0b vld=%0b exp in=%0b idx=%0d st=%0b gl=%0b hit=%0b pix=%0b vld=%0b",
                 name, d, last_hc, last_vc,
                 a.in_g, a.idx, a.st, a.gl, a.hit, a.pix, a.vld,
                 e.in_g, e.idx, e.st, e.gl, e.hit, e.pix, e.vld);
      end
    end
  endtask

  task automatic drive(bit t, int hc, int vc);
    b0.pixel_tick = t;     b1.pixel_tick = t;
    b0.hc = 10'(hc);       b1.hc = 10'(hc);
    b0.vc = 10'(vc);       b1.vc = 10'(vc);
    b0.board = board;      b1.board = board;
    b0.mode = mode;        b1.mode = mode;
    b0.cursor_col = 4'(cc0); b0.cursor_row = 4'(cr0);
    b1.cursor_col = 5'(cc1); b1.cursor_row = 3'(cr1);
  endtask

  task automatic step(bit t, int hc, int vc);
    out_t e, a;
    vec_t v;
    drive(t, hc, vc);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      e = model(d, last_hc, last_vc, last_ok, prev_tick);
      a = act(d);
      compare("stream", d, a, e, 1'b1);
      if (prev_tick) begin
        for (int i = 0; i < tbl.size(); i++) begin
          v = tbl[i];
          if (v.frm == cur_frame && v.d == d &&
              v.hc == last_hc && v.vc == last_vc) begin
            e.in_g = v.in_g; e.idx = v.idx; e.st = v.st;
            e.gl = v.gl; e.hit = v.hit; e.pix = v.pix; e.vld = 1;
            compare("table", d, a, e, 1'b0);
            tbl[i].seen = tbl[i].seen + 1;
          end
        end
      end
    end
    prev_tick = t;
    if (t) begin
      last_hc = hc;
      last_vc = vc;
      if (hc == 0 && vc == VO) frame_ok = 1;
      last_ok = frame_ok;
    end
    cur_hc = hc;
    cur_vc = vc;
  endtask

  task automatic do_reset(int hc, int vc);
    out_t z, a;
    rst = 1'b1;
    drive(1'b1, hc, vc);
    @(posedge clk);
    #1;
    z.in_g = 0; z.idx = 0; z.st = 0; z.gl = 0;
    z.hit = 0; z.pix = 0; z.vld = 0;
    for (int d = 0; d < 2; d++) begin
      a = act(d);
      compare("reset", d, a, z, 1'b1);
    end
    rst = 1'b0;
    frame_ok = 0;
    last_ok = 0;
    prev_tick = 0;
    last_hc = hc;
    last_vc = vc;
  endtask

  task automatic tick(int hc, int vc);
    if (idle_pct >= 100 ||
        (idle_pct > 0 && $urandom_range(0, 99) < idle_pct))
      step(1'b0, cur_hc, cur_vc);
    step(1'b1, hc, vc);
  endtask

  task automatic run_frame(int f);
    cur_frame = f;
    step(1'b0, cur_hc, cur_vc);
    step(1'b0, cur_hc, cur_vc);
    for (int vc = 0; vc < 525; vc++) begin
      tick(0, vc);
      if (sweep[vc]) begin
        for (int hc = HO - 1; hc <= SWEEP_END; hc++) begin
          if (f == 2 && vc == 100 && hc == 400) do_reset(hc, vc);
          else tick(hc, vc);
        end
      end
    end
  endtask

  task automatic set_lines(int n);
    for (int i = 0; i < 525; i++) sweep[i] = 0;
    for (int i = 0; i < n; i++) sweep[$urandom_range(30, 520)] = 1;
  endtask

  initial begin
    // frame 0: single-cell pattern, cursor on the last cell
    add(0, 0, 224,  35, 1,   0, 0, 1, 0, 0);
    add(0, 0, 254,  65, 1,  17, 1, 1, 0, 1);
    add(0, 0, 253,  64, 1,   0, 0, 0, 0, 0);
    add(0, 0, 283,  94, 1,  17, 1, 0, 0, 1);
    add(0, 0, 284,  94, 1,  18, 0, 1, 0, 0);
    add(0, 0, 703, 514, 1, 255, 0, 0, 1, 0);
    add(0, 0, 704, 514, 0,   0, 0, 0, 0, 0);
    add(0, 0, 703, 515, 0,   0, 0, 0, 0, 0);
    add(0, 1, 224,  35, 1,   0, 0, 1, 0, 0);
    add(0, 1, 360,  35, 1,  17, 1, 1, 0, 1);
    add(0, 1, 367,  42, 1,  17, 1, 0, 0, 1);
    add(0, 1, 232,  43, 1,  33, 0, 1, 0, 0);
    add(0, 1, 479,  98, 1, 255, 0, 0, 1, 0);
    add(0, 1, 480,  98, 0,   0, 0, 0, 0, 0);
    add(0, 1, 479,  99, 0,   0, 0, 0, 0, 0);
    // frame 1: cursor highlight plus grid lines on an empty board
    add(1, 0, 319, 100, 1,  35, 0, 0, 1, 1);
    add(1, 0, 349, 100, 1,  36, 0, 0, 0, 0);
    add(1, 0, 254, 100, 1,  33, 0, 1, 0, 1);
    add(1, 0, 314,  95, 1,  35, 0, 1, 1, 1);
    add(1, 1, 251,  54, 1,  67, 0, 0, 1, 1);
    add(1, 1, 259,  54, 1,  68, 0, 0, 0, 0);
    // frame 2 after mid-line reset, frame 3 resynced
    add(2, 0, 300, 200, 0,   0, 0, 0, 0, 0);
    add(3, 0, 224,  35, 1,   0, 1, 1, 0, 1);
    add(3, 1, 224,  35, 1,   0, 1, 1, 0, 1);

    board = '0; mode = 2'b00;
    cc0 = 0; cr0 = 0; cc1 = 0; cr1 = 0;
    frame_ok = 0; last_ok = 0; prev_tick = 0;
    last_hc = 0; last_vc = 0; cur_hc = 0; cur_vc = 0;
    cur_frame = -1; idle_pct = 0;

    rst = 1'b1;
    drive(1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_reset(0, 0);

    board = 256'd1 << 17; mode = 2'b00;
    cc0 = 15; cr0 = 15; cc1 = 31; cr1 = 7;
    idle_pct = 100;
    set_lines(0);
    foreach (tbl[i]) if (tbl[i].frm == 0) sweep[tbl[i].vc] = 1;
    run_frame(0);

    board = '0; mode = 2'b11;
    cc0 = 3; cr0 = 2; cc1 = 3; cr1 = 2;
    idle_pct = 0;
    set_lines(0);
    foreach (tbl[i]) if (tbl[i].frm == 1) sweep[tbl[i].vc] = 1;
    run_frame(1);

    board = '1; mode = 2'b00;
    cc0 = 5; cr0 = 5; cc1 = 5; cr1 = 5;
    idle_pct = 25;
    set_lines(0);
    sweep[40] = 1; sweep[90] = 1; sweep[100] = 1; sweep[200] = 1;
    run_frame(2);

    set_lines(2);
    sweep[35] = 1; sweep[60] = 1;
    run_frame(3);

    for (int f = 4; f < 6; f++) begin
      board = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
      mode = 2'($urandom_range(0, 3));
      cc0 = $urandom_range(0, 15); cr0 = $urandom_range(0, 15);
      cc1 = $urandom_range(0, 31); cr1 = $urandom_range(0, 7);
      idle_pct = $urandom_range(0, 50);
      set_lines(8);
      run_frame(f);
    end

    foreach (tbl[i]) begin
      checks++;
      if (tbl[i].seen == 0) begin
        errors++;
        $display("FAIL table_hit d%0d px=(%0d,%0d) got 0 visits, need >=1",
                 tbl[i].d, tbl[i].hc, tbl[i].vc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
